mem_port_arbiter: RTL

Shares one single-port synchronous memory (1-cycle registered read, write on clock edge when request & we) between the instruction-fetch requester (port 0) and the load/store requester (port 1). It accepts valid/ready requests, issues exactly one memory access at a time and steers the read data or write acknowledge back to the owning port. It sits between the core's IF/MEM stages and the shared memory instance.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant selector: round-robin or fixed (port 1 wins) on a tie.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        if (PRIO_MODE == PRIO_FIXED) gnt_o = 2'b10;
        else                         gnt_o = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Every grant is an accepted handshake, so last_grant follows the grant.
  always_comb begin
    last_d = last_q;
    if (gnt_o[1])      last_d = PORT_DATA;
    else if (gnt_o[0]) last_d = PORT_INST;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= PORT_DATA;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (port 0)
// and load/store (port 1); one access in flight, response two cycles after accept.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int PRIO_MODE  = PRIO_RR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  grant_id
);

  arb_state_e            state_q, state_d;
  logic                  mem_request_q, mem_request_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  grant_id_q, grant_id_d;
  logic                  store_q, store_d;
  logic                  accept_en, accept;
  logic [1:0]            gnt;

  assign accept_en = (state_q == ST_IDLE) || (state_q == ST_RESP);

  rr_arbiter2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i ({req1_valid, req0_valid}),
    .en_i  (accept_en),
    .gnt_o (gnt)
  );

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign accept      = |gnt;
  assign mem_request = mem_request_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant_id    = grant_id_q;

  always_comb begin
    state_d       = state_q;
    mem_request_d = mem_request_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    grant_id_d    = grant_id_q;
    store_d       = store_q;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    rsp0_rdata    = '0;
    rsp1_rdata    = '0;

    case (state_q)
      ST_ISSUE: begin
        state_d       = ST_RESP;
        mem_request_d = 1'b0;
        mem_we_d      = 1'b0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (grant_id_q == PORT_INST) begin
          rsp0_valid = 1'b1;
          rsp0_rdata = mem_rdata;
        end else begin
          rsp1_valid = 1'b1;
          rsp1_rdata = store_q ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase

    // Acceptance in RESP overrides the return to IDLE for back-to-back issue.
    if (accept) begin
      state_d       = ST_ISSUE;
      mem_request_d = 1'b1;
      if (gnt[1]) begin
        grant_id_d  = PORT_DATA;
        mem_addr_d  = req1_addr;
        mem_we_d    = req1_we;
        mem_wdata_d = req1_wdata;
        store_d     = req1_we;
      end else begin
        grant_id_d  = PORT_INST;
        mem_addr_d  = req0_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        store_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_request_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      grant_id_q    <= PORT_INST;
      store_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_request_q <= mem_request_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      grant_id_q    <= grant_id_d;
      store_q       <= store_d;
    end
  end

endmodule
